// File: rtl/mesa_ascii2byte_if.sv
// Mesa-Bus ASCII receive interface: character strobe in, byte stream out, error status.
interface mesa_ascii2byte_if #(
  parameter int unsigned FIFO_AW = 2
);
  logic               rx_char_en;
  logic [7:0]         rx_char_d;
  logic               byte_vld;
  logic [7:0]         byte_d;
  logic               byte_last;
  logic               byte_rdy;
  logic [FIFO_AW:0]   fifo_lvl;
  logic               err_char;
  logic               err_ovf;
  logic               clr_err;

  // Producer/consumer side (UART receiver plus packet consumer)
  modport master (
    output rx_char_en, rx_char_d, byte_rdy, clr_err,
    input  byte_vld, byte_d, byte_last, fifo_lvl, err_char, err_ovf
  );

  // Decoder side
  modport slave (
    input  rx_char_en, rx_char_d, byte_rdy, clr_err,
    output byte_vld, byte_d, byte_last, fifo_lvl, err_char, err_ovf
  );
endinterface

// File: rtl/mesa_ascii2byte.sv
// ASCII hex to byte decoder: pairs nibbles into bytes, tags the last byte of each
// line, and buffers {last, byte} in a small FIFO with a valid/ready head.
module mesa_ascii2byte #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               reset,
  mesa_ascii2byte_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned LVL_W = FIFO_AW + 1;

  typedef enum logic { PH_HI = 1'b0, PH_LO = 1'b1 } phase_t;
  typedef enum logic [1:0] { C_HEX, C_EOL, C_SPC, C_ILL } cls_t;

  phase_t             r_phase, w_phase_nxt;
  logic [3:0]         r_hi_nib, w_hi_nib_nxt;
  logic               r_hold_vld, w_hold_vld_nxt;
  logic [7:0]         r_hold_d, w_hold_d_nxt;
  logic               r_push_vld, w_push_vld_nxt;
  logic [8:0]         r_push_d, w_push_d_nxt;
  logic               w_err_set;

  cls_t               w_cls;
  logic [3:0]         w_nib;

  logic [8:0]         r_ram [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [LVL_W-1:0]   r_lvl, w_lvl_nxt;
  logic               r_byte_vld;
  logic [8:0]         r_head, w_head_nxt;
  logic               r_err_char, r_err_ovf;
  logic               w_pop, w_full, w_wr, w_ovf;

  // Character classification and nibble value
  always_comb begin
    w_cls = C_ILL;
    w_nib = 4'h0;
    if (bus.rx_char_d >= 8'h30 && bus.rx_char_d <= 8'h39) begin
      w_cls = C_HEX;
      w_nib = 4'(bus.rx_char_d - 8'h30);
    end else if (bus.rx_char_d >= 8'h41 && bus.rx_char_d <= 8'h46) begin
      w_cls = C_HEX;
      w_nib = 4'(bus.rx_char_d - 8'h37);
    end else if (bus.rx_char_d >= 8'h61 && bus.rx_char_d <= 8'h66) begin
      w_cls = C_HEX;
      w_nib = 4'(bus.rx_char_d - 8'h57);
    end else if (bus.rx_char_d == 8'h0A || bus.rx_char_d == 8'h0D) begin
      w_cls = C_EOL;
    end else if (bus.rx_char_d == 8'h20) begin
      w_cls = C_SPC;
    end
  end

  // Nibble-phase FSM next state, hold register and push request
  always_comb begin
    w_phase_nxt    = r_phase;
    w_hi_nib_nxt   = r_hi_nib;
    w_hold_vld_nxt = r_hold_vld;
    w_hold_d_nxt   = r_hold_d;
    w_push_vld_nxt = 1'b0;
    w_push_d_nxt   = r_push_d;
    w_err_set      = 1'b0;
    if (bus.rx_char_en) begin
      case (w_cls)
        C_HEX: begin
          if (r_phase == PH_HI) begin
            w_hi_nib_nxt = w_nib;
            w_phase_nxt  = PH_LO;
          end else begin
            w_phase_nxt = PH_HI;
            if (r_hold_vld) begin
              w_push_vld_nxt = 1'b1;
              w_push_d_nxt   = {1'b0, r_hold_d};
            end
            w_hold_d_nxt   = {r_hi_nib, w_nib};
            w_hold_vld_nxt = 1'b1;
          end
        end
        C_EOL: begin
          if (r_hold_vld) begin
            w_push_vld_nxt = 1'b1;
            w_push_d_nxt   = {1'b1, r_hold_d};
            w_hold_vld_nxt = 1'b0;
          end
          if (r_phase == PH_LO) begin
            w_err_set   = 1'b1;
            w_phase_nxt = PH_HI;
          end
        end
        C_SPC: begin
          if (r_phase == PH_LO) begin
            w_err_set   = 1'b1;
            w_phase_nxt = PH_HI;
          end
        end
        default: begin
          w_err_set   = 1'b1;
          w_phase_nxt = PH_HI;
        end
      endcase
    end
  end

  // Decoder state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase    <= PH_HI;
      r_hi_nib   <= 4'h0;
      r_hold_vld <= 1'b0;
      r_hold_d   <= 8'h00;
      r_push_vld <= 1'b0;
      r_push_d   <= 9'h000;
    end else begin
      r_phase    <= w_phase_nxt;
      r_hi_nib   <= w_hi_nib_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_hold_d   <= w_hold_d_nxt;
      r_push_vld <= w_push_vld_nxt;
      r_push_d   <= w_push_d_nxt;
    end
  end

  // FIFO control: write/pop qualification, next level and registered head
  always_comb begin
    w_pop        = r_byte_vld & bus.byte_rdy;
    w_full       = (r_lvl == LVL_W'(DEPTH));
    w_wr         = r_push_vld & (~w_full | w_pop);
    w_ovf        = r_push_vld & w_full & ~w_pop;
    w_rd_ptr_nxt = r_rd_ptr + FIFO_AW'(w_pop);
    w_lvl_nxt    = r_lvl + LVL_W'(w_wr) - LVL_W'(w_pop);
    // A write landing on the next head location is forwarded into the head register
    if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = r_push_d;
    end else begin
      w_head_nxt = r_ram[w_rd_ptr_nxt];
    end
  end

  // FIFO storage, pointers, level and head registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_ram[i] <= 9'h000;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_lvl      <= '0;
      r_byte_vld <= 1'b0;
      r_head     <= 9'h000;
    end else begin
      if (w_wr) begin
        r_ram[r_wr_ptr] <= r_push_d;
        r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
      end
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_lvl      <= w_lvl_nxt;
      r_byte_vld <= (w_lvl_nxt != '0);
      r_head     <= w_head_nxt;
    end
  end

  // Sticky error flags; a new error on the clearing edge wins
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_char <= 1'b0;
      r_err_ovf  <= 1'b0;
    end else begin
      if (w_err_set)        r_err_char <= 1'b1;
      else if (bus.clr_err) r_err_char <= 1'b0;
      if (w_ovf)            r_err_ovf  <= 1'b1;
      else if (bus.clr_err) r_err_ovf  <= 1'b0;
    end
  end

  assign bus.byte_vld  = r_byte_vld;
  assign bus.byte_d    = r_head[7:0];
  assign bus.byte_last = r_head[8];
  assign bus.fifo_lvl  = r_lvl;
  assign bus.err_char  = r_err_char;
  assign bus.err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_mesa_ascii2byte.sv
// Directed bench for mesa_ascii2byte: vector table of packets plus overflow,
// full push/pop, and reset-mid-packet sequences.
module tb_mesa_ascii2byte;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [8:0] got [$];

  always #5 clk = ~clk;

  mesa_ascii2byte_if #(.FIFO_AW(2)) bus ();

  mesa_ascii2byte #(.FIFO_AW(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Record every beat that will be popped on the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.byte_vld && bus.byte_rdy) got.push_back({bus.byte_last, bus.byte_d});
  end

  typedef struct {
    string            s;
    int               n;
    logic [1:0][8:0]  exp;
    logic             ec;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller is positioned just after a rising edge; one character per cycle
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      bus.rx_char_en = 1'b1;
      bus.rx_char_d  = s[i];
      @(posedge clk); #1;
    end
    bus.rx_char_en = 1'b0;
    bus.rx_char_d  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_pulse();
    bus.clr_err = 1'b1;
    @(posedge clk); #1;
    bus.clr_err = 1'b0;
  endtask

  // Two hex chars whose push lands on the same edge as a single pop while full
  task automatic pair_pop(input byte hi, input byte lo, input string name);
    bus.rx_char_en = 1'b1;
    bus.rx_char_d  = hi;
    @(posedge clk); #1;
    bus.rx_char_d  = lo;
    @(posedge clk); #1;
    bus.rx_char_en = 1'b0;
    bus.byte_rdy   = 1'b1;
    @(posedge clk); #1;
    bus.byte_rdy   = 1'b0;
    chk({name, "_lvl"}, 32'(bus.fifo_lvl), 32'd4);
    chk({name, "_ovf"}, 32'(bus.err_ovf), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_vld"},  32'(bus.byte_vld),  32'd0);
    chk({tag, "_d"},    32'(bus.byte_d),    32'd0);
    chk({tag, "_last"}, 32'(bus.byte_last), 32'd0);
    chk({tag, "_lvl"},  32'(bus.fifo_lvl),  32'd0);
    chk({tag, "_echr"}, 32'(bus.err_char),  32'd0);
    chk({tag, "_eovf"}, 32'(bus.err_ovf),   32'd0);
  endtask

  initial begin
    vecs[0] = '{s: "A5\n",            n: 1, exp: {9'h000, 9'h1A5}, ec: 1'b0};
    vecs[1] = '{s: "12aB3\n",         n: 2, exp: {9'h1AB, 9'h012}, ec: 1'b1};
    vecs[2] = '{s: "1G2\n",           n: 0, exp: {9'h000, 9'h000}, ec: 1'b1};
    vecs[3] = '{s: "\015\012\012",    n: 0, exp: {9'h000, 9'h000}, ec: 1'b0};
    vecs[4] = '{s: "de AD\n",         n: 2, exp: {9'h1AD, 9'h0DE}, ec: 1'b0};
    vecs[5] = '{s: "f\n",             n: 0, exp: {9'h000, 9'h000}, ec: 1'b1};
    vecs[6] = '{s: "7 8\n",           n: 0, exp: {9'h000, 9'h000}, ec: 1'b1};
    vecs[7] = '{s: "9f\015\012",      n: 1, exp: {9'h000, 9'h19F}, ec: 1'b0};

    rst_n          = 1'b0;
    bus.rx_char_en = 1'b0;
    bus.rx_char_d  = 8'h00;
    bus.byte_rdy   = 1'b1;
    bus.clr_err    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    idle(1);

    // Table-driven packets with the consumer always ready
    for (int v = 0; v < 8; v++) begin
      clr_pulse();
      chk($sformatf("v%0d_clr", v), 32'(bus.err_char), 32'd0);
      got.delete();
      send(vecs[v].s);
      idle(6);
      chk($sformatf("v%0d_cnt", v), 32'(got.size()), 32'(vecs[v].n));
      for (int j = 0; j < vecs[v].n; j++) begin
        if (j < got.size()) chk($sformatf("v%0d_b%0d", v, j), 32'(got[j]), 32'(vecs[v].exp[j]));
      end
      chk($sformatf("v%0d_echr", v), 32'(bus.err_char), 32'(vecs[v].ec));
      chk($sformatf("v%0d_eovf", v), 32'(bus.err_ovf), 32'd0);
      chk($sformatf("v%0d_lvl", v), 32'(bus.fifo_lvl), 32'd0);
    end

    // Overflow: consumer stalled, eight bytes offered to a four-entry FIFO
    clr_pulse();
    got.delete();
    bus.byte_rdy = 1'b0;
    send("0102030405060708\n");
    idle(4);
    chk("ovf_lvl",  32'(bus.fifo_lvl), 32'd4);
    chk("ovf_flag", 32'(bus.err_ovf),  32'd1);
    chk("ovf_vld",  32'(bus.byte_vld), 32'd1);
    chk("ovf_head", 32'({bus.byte_last, bus.byte_d}), 32'h001);
    bus.byte_rdy = 1'b1;
    idle(8);
    chk("ovf_cnt", 32'(got.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      if (j < got.size()) chk($sformatf("ovf_b%0d", j), 32'(got[j]), 32'(j + 1));
    end
    chk("ovf_empty", 32'(bus.fifo_lvl), 32'd0);
    clr_pulse();
    chk("ovf_clr", 32'(bus.err_ovf), 32'd0);

    // Full FIFO with each push paired with a pop on the same edge
    got.delete();
    bus.byte_rdy = 1'b0;
    send("1011121314");
    idle(3);
    chk("pp_fill", 32'(bus.fifo_lvl), 32'd4);
    pair_pop("1", "5", "pp15");
    pair_pop("1", "6", "pp16");
    pair_pop("1", "7", "pp17");
    pair_pop("1", "8", "pp18");
    chk("pp_popcnt", 32'(got.size()), 32'd4);
    bus.byte_rdy = 1'b1;
    send("\n");
    idle(8);
    chk("pp_cnt", 32'(got.size()), 32'd9);
    for (int j = 0; j < 9; j++) begin
      if (j < got.size())
        chk($sformatf("pp_b%0d", j), 32'(got[j]), (j == 8) ? 32'h118 : 32'(8'h10 + j));
    end
    chk("pp_ovf", 32'(bus.err_ovf), 32'd0);
    chk("pp_lvl", 32'(bus.fifo_lvl), 32'd0);

    // Reset mid-packet with entries queued and a byte held
    bus.byte_rdy = 1'b0;
    send("1122DE");
    idle(2);
    chk("rm_pre_lvl", 32'(bus.fifo_lvl), 32'd2);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rm_in");
    idle(2);
    chk_reset_outputs("rm_hold");
    rst_n = 1'b1;
    bus.byte_rdy = 1'b1;
    idle(1);
    got.delete();
    send("AD\n");
    idle(6);
    chk("rm_cnt", 32'(got.size()), 32'd1);
    if (got.size() > 0) chk("rm_b0", 32'(got[0]), 32'h1AD);
    chk("rm_echr", 32'(bus.err_char), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mesa_ascii2byte.md
# mesa_ascii2byte

Receive-side decoder for the Mesa-Bus ASCII link: it is the counterpart of the byte-to-ASCII transmit path. It takes ASCII hex characters from a UART receiver, pairs nibbles into binary bytes, and tags the final byte of each line-terminated packet. Bytes are buffered in a small FIFO with a valid/ready output. It sits between the Ro-side UART receiver and the host-side or loopback packet consumer.

## Interface
- `FIFO_AW`, default 2: FIFO address width. Depth is 2^FIFO_AW entries, each 9 bits wide ({last, byte}).
- `clk`, in, 1: sole clock; everything is rising-edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `rx_char_en`, in, 1: one-cycle strobe; `rx_char_d` is valid.
- `rx_char_d`, in, 8: ASCII character.
- `byte_vld`, out, 1: FIFO head is valid.
- `byte_d`, out, 8: FIFO head data.
- `byte_last`, out, 1: FIFO head is the last byte of its packet.
- `byte_rdy`, in, 1: consumer pops the head on an edge where `byte_vld` and `byte_rdy` are both 1.
- `fifo_lvl`, out, FIFO_AW+1: current occupancy, 0..2^FIFO_AW.
- `err_char`, out, 1: sticky error flag for an illegal character or an odd nibble count.
- `err_ovf`, out, 1: sticky flag; a byte was dropped because the FIFO was full.
- `clr_err`, in, 1: synchronous clear of both sticky flags.

## Operation
- **Character classes:**
  - HEX: 0x30-0x39, 0x41-0x46, 0x61-0x66. Upper and lower case decode identically.
  - EOL: 0x0A or 0x0D.
  - SPACE: 0x20.
  - Any other value is ILLEGAL.
- **State:** `phase` (0 = expecting high nibble), `hi_nib[3:0]`, `hold_vld`, `hold_d[7:0]`, and a push pipeline register `push_vld` / `push_d[8:0]`.
- **HEX with phase 0:** store the nibble in `hi_nib` and set phase to 1.
- **HEX with phase 1:** form the byte {hi_nib, nib} and set phase to 0.
  - If `hold_vld` is 1, push {0, hold_d}.
  - The new byte then goes into `hold_d` and `hold_vld` is set to 1.
- **EOL:**
  - If `hold_vld` is 1, push {1, hold_d} and clear `hold_vld`.
  - If phase is 1, discard the dangling nibble, set `err_char`, and set phase to 0.
  - If `hold_vld` is 0, nothing is pushed. Empty lines and CR+LF produce no output.
- **SPACE:** if phase is 1, discard the nibble, set `err_char`, and set phase to 0. If phase is 0, SPACE is ignored. The hold register is unaffected in both cases.
- **ILLEGAL:** set `err_char` and set phase to 0. The hold register is kept, so the packet continues.
- **Push:** `push_vld` is registered and writes the FIFO on the following edge.
  - If the FIFO is full and no pop occurs on that edge, the entry is dropped and `err_ovf` is set.
  - A push and a pop on the same edge while full is legal: occupancy is unchanged and there is no overflow.
  - A push and a pop on the same edge while empty writes the FIFO and keeps `byte_vld` at 0 until the next edge. There is no fall-through.
- **FIFO:** circular pointers of FIFO_AW bits that wrap modulo the depth. Occupancy is kept as a separate (FIFO_AW+1)-bit counter.
- **`clr_err` versus a new error on the same edge:** the set wins.
- **`byte_d` / `byte_last` when empty:** they hold the last read location. The value is don't-care, but must not be X after reset; the RAM is reset to 0.

## Timing
- **Reset values:** `byte_vld`=0, `byte_d`=0x00, `byte_last`=0, `fifo_lvl`=0, `err_char`=0, `err_ovf`=0. All internal state is cleared (phase 0, `hold_vld` 0, `push_vld` 0, pointers 0).
- **Reset mid-packet:** the partial nibble, the held byte and the FIFO contents are all discarded. Decoding restarts at the high nibble.
- **Latency:** for a character sampled at edge k that causes a push, the FIFO is written at edge k+1. `byte_vld` and `fifo_lvl` reflect the write after edge k+1.
- **Held byte:** the last byte of a packet stays in the hold register until its EOL arrives, so it appears 2 edges after the EOL.
- **Throughput:** at most one character per cycle. Back-to-back `rx_char_en` is legal.
- **Pop:** the head advances on the edge where `byte_vld` and `byte_rdy` are both 1. The next entry is visible after that edge with no bubble.

## Test plan
- **Basic packet:** "A5" LF with `byte_rdy`=1. Required: one beat, 0xA5 with last=1; both error flags stay 0.
- **Case and odd nibble:**
  - "12aB3" LF. Required: 0x12 last=0, then 0xAB last=1. The dangling "3" is discarded and `err_char` becomes 1.
  - `clr_err` pulse. Required: `err_char` returns to 0.
- **Illegal character:** "1G2" LF. Required: `err_char`=1 and no byte is output. The 'G' resets the phase, leaving "2" as a dangling nibble.
- **Overflow, FIFO_AW=2:** hold `byte_rdy`=0 and send "0102030405060708" LF. Required:
  - `fifo_lvl` saturates at 4 with 0x01-0x04 retained, and `err_ovf`=1.
  - Releasing `byte_rdy` drains exactly 0x01, 0x02, 0x03, 0x04, all with last=0.
- **Push and pop together at full:** keep the FIFO at 4 entries and pop on the same edge as each push. Required: `fifo_lvl` stays 4, `err_ovf` stays 0, and the pointers wrap correctly.
- **Reset mid-packet:** send "DE", then assert reset for 2 cycles, then send "AD" LF. Required: the only output is 0xAD with last=1, and all outputs are at their reset values during reset.
